// File: rtl/dfb_pkg.sv
// Shared definitions for the X-bus cycle engine: state encodings and strobe levels.
package dfb_pkg;

  // Bus cycle engine states.
  typedef enum logic [2:0] {
    XBC_IDLE  = 3'd0,
    XBC_ADDR  = 3'd1,
    XBC_STRB  = 3'd2,
    XBC_WAIT  = 3'd3,
    XBC_TERM  = 3'd4,
    XBC_RECOV = 3'd5
  } xbc_state_e;

  // X-bus strobes are active low.
  localparam logic STRB_ACT   = 1'b0;
  localparam logic STRB_INACT = 1'b1;

  // Level to drive on a data strobe for a given byte enable.
  function automatic logic strb_level(input logic en);
    return en ? STRB_ACT : STRB_INACT;
  endfunction

endpackage

// File: rtl/dfb_sync.sv
// Flop-chain synchroniser for active-low asynchronous host signals.
// Resets to 1 so the synchronised signal starts out negated.
module dfb_sync #(
  parameter int STAGES = 2
) (
  input  logic CLOCK,
  input  logic _RST,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through STAGES flops.
  always_ff @(posedge CLOCK or negedge _RST) begin
    if (!_RST) begin
      chain <= '1;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/xbus_cycle.sv
// 68000-style asynchronous bus cycle engine for the host (X) bus.
// Turns one local read/write request into _XAS/_XUDS/_XLDS/XRW strobes while
// the arbiter holds the bus, and terminates on _XDTACK, _XBERR or timeout.
//
// Local handshake: REQ is a level held by the requester until it sees the
// one-clock ACK pulse; ADDR/RW/UDS/LDS/WDATA must be stable while REQ is high
// in IDLE (they are latched when the cycle starts). BERR and RDATA are valid
// with ACK; RDATA then holds until the next read completes.
module xbus_cycle
  import dfb_pkg::*;
#(
  parameter int AW       = 23,
  parameter int DW       = 16,
  parameter int SYNC     = 2,
  parameter int TIMEOUT  = 255,
  parameter int RECOVERY = 1
) (
  input  logic          CLOCK,
  input  logic          _RST,
  input  logic          HELD,
  input  logic          REQ,
  input  logic          RW,
  input  logic          UDS,
  input  logic          LDS,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] WDATA,
  output logic          ACK,
  output logic          BERR,
  output logic [DW-1:0] RDATA,
  input  logic          _XDTACK,
  input  logic          _XBERR,
  input  logic [DW-1:0] XD_IN,
  output logic [AW-1:0] XA,
  output logic [DW-1:0] XD_OUT,
  output logic          XRW,
  output logic          _XAS,
  output logic          _XUDS,
  output logic          _XLDS,
  output logic          XA_OE,
  output logic          XD_OE,
  output logic          BUSY
);

  localparam int TW  = (TIMEOUT  > 0) ? $clog2(TIMEOUT + 1)  : 1;
  localparam int RCW = (RECOVERY > 0) ? $clog2(RECOVERY + 1) : 1;

  xbc_state_e     state;
  logic [TW-1:0]  tmo_cnt;
  logic [RCW-1:0] rec_cnt;
  logic           uds_q;
  logic           lds_q;
  logic           dtack_s;
  logic           berr_s;
  logic           rec_done;

  dfb_sync #(.STAGES(SYNC)) u_sync_dtack (
    .CLOCK (CLOCK),
    ._RST  (_RST),
    .d     (_XDTACK),
    .q     (dtack_s)
  );

  dfb_sync #(.STAGES(SYNC)) u_sync_berr (
    .CLOCK (CLOCK),
    ._RST  (_RST),
    .d     (_XBERR),
    .q     (berr_s)
  );

  // RECOV has lasted RECOVERY clocks once this clock completes (at least one).
  assign rec_done = (int'(rec_cnt) + 1) >= RECOVERY;

  assign BUSY = (state != XBC_IDLE);

  // Cycle sequencer; every bus-facing and local output is a register here.
  always_ff @(posedge CLOCK or negedge _RST) begin
    if (!_RST) begin
      state   <= XBC_IDLE;
      XA      <= '0;
      XD_OUT  <= '0;
      XRW     <= 1'b1;
      _XAS    <= STRB_INACT;
      _XUDS   <= STRB_INACT;
      _XLDS   <= STRB_INACT;
      XA_OE   <= 1'b0;
      XD_OE   <= 1'b0;
      ACK     <= 1'b0;
      BERR    <= 1'b0;
      RDATA   <= '0;
      tmo_cnt <= '0;
      rec_cnt <= '0;
      uds_q   <= 1'b0;
      lds_q   <= 1'b0;
    end else begin
      ACK  <= 1'b0;
      BERR <= 1'b0;
      case (state)
        XBC_IDLE: begin
          XA_OE <= HELD;
          if (REQ && !UDS && !LDS) begin
            // Nothing to transfer: acknowledge locally without touching the bus.
            ACK <= 1'b1;
          end else if (REQ && HELD) begin
            state  <= XBC_ADDR;
            XA     <= ADDR;
            XD_OUT <= WDATA;
            XRW    <= RW;
            uds_q  <= UDS;
            lds_q  <= LDS;
            XA_OE  <= 1'b1;
            XD_OE  <= ~RW;
          end
        end
        XBC_ADDR: begin
          // Address setup done; reads assert data strobes together with _XAS.
          state <= XBC_STRB;
          _XAS  <= STRB_ACT;
          if (XRW) begin
            _XUDS <= strb_level(uds_q);
            _XLDS <= strb_level(lds_q);
          end
        end
        XBC_STRB: begin
          // Writes assert data strobes one clock after _XAS.
          state   <= XBC_WAIT;
          tmo_cnt <= '0;
          _XUDS   <= strb_level(uds_q);
          _XLDS   <= strb_level(lds_q);
        end
        XBC_WAIT: begin
          if (!berr_s || (tmo_cnt == TW'(TIMEOUT))) begin
            state <= XBC_TERM;
            ACK   <= 1'b1;
            BERR  <= 1'b1;
            _XAS  <= STRB_INACT;
            _XUDS <= STRB_INACT;
            _XLDS <= STRB_INACT;
          end else if (!dtack_s) begin
            state <= XBC_TERM;
            ACK   <= 1'b1;
            _XAS  <= STRB_INACT;
            _XUDS <= STRB_INACT;
            _XLDS <= STRB_INACT;
            if (XRW) begin
              RDATA <= XD_IN;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        XBC_TERM: begin
          // Write data was held through TERM; release it now.
          state   <= XBC_RECOV;
          XD_OE   <= 1'b0;
          rec_cnt <= '0;
        end
        XBC_RECOV: begin
          // Do not start another cycle until the host has let go of its responses.
          if (rec_done && dtack_s && berr_s) begin
            state <= XBC_IDLE;
            XRW   <= 1'b1;
            XA_OE <= HELD;
          end else if (!rec_done) begin
            rec_cnt <= rec_cnt + 1'b1;
          end
        end
        default: begin
          state <= XBC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_cycle.sv
// Directed bench for xbus_cycle: the driver issues cycles and plays the host;
// expected completions {BERR, RDATA} are queued and checked by a monitor on ACK.
module tb_xbus_cycle;

  localparam int AW = 23;
  localparam int DW = 16;
  localparam int W  = DW + 1;

  logic          CLOCK;
  logic          _RST;
  logic          HELD;
  logic          REQ;
  logic          RW;
  logic          UDS;
  logic          LDS;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] WDATA;
  logic          ACK;
  logic          BERR;
  logic [DW-1:0] RDATA;
  logic          _XDTACK;
  logic          _XBERR;
  logic [DW-1:0] XD_IN;
  logic [AW-1:0] XA;
  logic [DW-1:0] XD_OUT;
  logic          XRW;
  logic          _XAS;
  logic          _XUDS;
  logic          _XLDS;
  logic          XA_OE;
  logic          XD_OE;
  logic          BUSY;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  xbus_cycle #(
    .AW(AW), .DW(DW), .SYNC(2), .TIMEOUT(15), .RECOVERY(1)
  ) dut (
    .CLOCK(CLOCK), ._RST(_RST), .HELD(HELD), .REQ(REQ), .RW(RW),
    .UDS(UDS), .LDS(LDS), .ADDR(ADDR), .WDATA(WDATA), .ACK(ACK),
    .BERR(BERR), .RDATA(RDATA), ._XDTACK(_XDTACK), ._XBERR(_XBERR),
    .XD_IN(XD_IN), .XA(XA), .XD_OUT(XD_OUT), .XRW(XRW), ._XAS(_XAS),
    ._XUDS(_XUDS), ._XLDS(_XLDS), .XA_OE(XA_OE), .XD_OE(XD_OE), .BUSY(BUSY)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s wait bound expired", name);
  endtask

  task automatic issue(input logic rw, input logic uds, input logic lds,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    RW    = rw;
    UDS   = uds;
    LDS   = lds;
    ADDR  = a;
    WDATA = wd;
    REQ   = 1'b1;
  endtask

  task automatic wait_as_low(input string name);
    int n;
    n = 0;
    while (_XAS !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    if (_XAS !== 1'b0) bound_fail(name);
  endtask

  // Returns the number of clock edges until ACK is seen; drops REQ on ACK.
  task automatic wait_ack(input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ACK !== 1'b1 && n < 60);
    if (ACK !== 1'b1) bound_fail(name);
    REQ = 1'b0;
  endtask

  task automatic host_release();
    _XDTACK = 1'b1;
    _XBERR  = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    if (BUSY !== 1'b0) bound_fail(name);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLOCK) begin
    if (ACK === 1'b1) begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      got = {BERR, RDATA};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack actual=%h required=no_ack", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL ack_result actual=%h required=%h", got, exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic lds_seen_low;
    _RST    = 1'b0;
    HELD    = 1'b0;
    REQ     = 1'b0;
    RW      = 1'b1;
    UDS     = 1'b0;
    LDS     = 1'b0;
    ADDR    = '0;
    WDATA   = '0;
    XD_IN   = '0;
    _XDTACK = 1'b1;
    _XBERR  = 1'b1;
    repeat (3) tick();

    // Reset state: {_XAS,_XUDS,_XLDS,XRW,XA_OE,XD_OE,ACK,BERR,BUSY}
    check("reset_ctrl", {23'd0, _XAS, _XUDS, _XLDS, XRW, XA_OE, XD_OE, ACK, BERR, BUSY},
          32'b1_1110_0000);
    check("reset_rdata", {16'd0, RDATA}, 32'h0000);
    _RST = 1'b1;
    tick();
    HELD = 1'b1;
    tick();
    check("held_xa_oe", {31'd0, XA_OE}, 32'd1);

    // Word read, _XDTACK three clocks after _XAS.
    exp_q.push_back({1'b0, 16'hBEEF});
    issue(1'b1, 1'b1, 1'b1, 23'h7F8000, 16'h0000);
    wait_as_low("read_as");
    check("read_xa", {9'd0, XA}, 32'h007F8000);
    check("read_strobes", {29'd0, XRW, _XUDS, _XLDS}, 32'b100);
    repeat (3) tick();
    XD_IN   = 16'hBEEF;
    _XDTACK = 1'b0;
    wait_ack("read_ack", n);
    host_release();
    wait_idle("read_idle");
    check("read_rdata_hold", {16'd0, RDATA}, 32'hBEEF);

    // Latency with _XDTACK already low: ACK in the 5th clock counting the REQ clock.
    XD_IN   = 16'h1234;
    _XDTACK = 1'b0;
    exp_q.push_back({1'b0, 16'h1234});
    issue(1'b1, 1'b1, 1'b1, 23'h000400, 16'h0000);
    wait_ack("lat_ack", n);
    check("read_latency", n + 1, 32'd5);
    host_release();
    wait_idle("lat_idle");

    // Upper-byte write.
    exp_q.push_back({1'b0, 16'h1234});
    issue(1'b0, 1'b1, 1'b0, 23'h000123, 16'h12AB);
    tick();
    check("wr_addr_phase", {28'd0, XD_OE, _XAS, XRW, XA_OE}, 32'b1101);
    check("wr_xd_out", {16'd0, XD_OUT}, 32'h12AB);
    tick();
    check("wr_strb_phase", {29'd0, _XAS, _XUDS, _XLDS}, 32'b011);
    tick();
    check("wr_data_strobe", {29'd0, _XAS, _XUDS, _XLDS}, 32'b001);
    _XDTACK = 1'b0;
    lds_seen_low = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (_XLDS !== 1'b1) lds_seen_low = 1'b1;
    end while (ACK !== 1'b1 && n < 20);
    if (ACK !== 1'b1) bound_fail("wr_ack");
    REQ = 1'b0;
    check("wr_lds_idle", {31'd0, lds_seen_low}, 32'd0);
    check("wr_term", {28'd0, XD_OE, _XAS, _XUDS, _XLDS}, 32'b1111);
    tick();
    check("wr_recov_xd_oe", {31'd0, XD_OE}, 32'd0);
    host_release();
    wait_idle("wr_idle");

    // _XBERR and _XDTACK together: bus error wins; RECOV waits for both negated.
    exp_q.push_back({1'b1, 16'h1234});
    issue(1'b1, 1'b1, 1'b1, 23'h001000, 16'h0000);
    wait_as_low("berr_as");
    XD_IN   = 16'hDEAD;
    _XDTACK = 1'b0;
    _XBERR  = 1'b0;
    wait_ack("berr_ack", n);
    _XDTACK = 1'b1;
    repeat (6) tick();
    check("berr_recov_hold", {31'd0, BUSY}, 32'd1);
    _XBERR = 1'b1;
    wait_idle("berr_idle");

    // Timeout: no response, ACK+BERR 16 clocks after WAIT entry.
    exp_q.push_back({1'b1, 16'h1234});
    issue(1'b1, 1'b1, 1'b1, 23'h002000, 16'h0000);
    wait_as_low("tmo_as");
    tick();
    wait_ack("tmo_ack", n);
    check("tmo_clocks", n, 32'd16);
    check("tmo_strobes", {29'd0, _XAS, _XUDS, _XLDS}, 32'b111);
    wait_idle("tmo_idle");

    // HELD drops during WAIT: cycle completes normally.
    exp_q.push_back({1'b0, 16'h5A5A});
    issue(1'b1, 1'b1, 1'b1, 23'h003000, 16'h0000);
    wait_as_low("hdrop_as");
    tick();
    HELD = 1'b0;
    tick();
    XD_IN   = 16'h5A5A;
    _XDTACK = 1'b0;
    wait_ack("hdrop_ack", n);
    host_release();
    wait_idle("hdrop_idle");
    tick();
    check("hdrop_xa_oe", {31'd0, XA_OE}, 32'd0);

    // Request without HELD waits in IDLE until HELD returns.
    issue(1'b1, 1'b1, 1'b1, 23'h004000, 16'h0000);
    repeat (5) tick();
    check("noheld_wait", {29'd0, BUSY, XA_OE, _XAS}, 32'b001);
    exp_q.push_back({1'b0, 16'h0F0F});
    HELD = 1'b1;
    wait_as_low("held_as");
    XD_IN   = 16'h0F0F;
    _XDTACK = 1'b0;
    wait_ack("held_ack", n);
    host_release();
    wait_idle("held_idle");

    // No byte enables: local ACK after one clock, no bus activity.
    exp_q.push_back({1'b0, 16'h0F0F});
    issue(1'b1, 1'b0, 1'b0, 23'h005000, 16'h0000);
    wait_ack("noen_ack", n);
    check("noen_clocks", n, 32'd1);
    check("noen_bus", {30'd0, BUSY, _XAS}, 32'b01);

    // REQ dropped before ACK: cycle still completes.
    exp_q.push_back({1'b0, 16'hC3C3});
    issue(1'b1, 1'b1, 1'b0, 23'h2AAAAA, 16'h0000);
    wait_as_low("drop_as");
    REQ = 1'b0;
    tick();
    XD_IN   = 16'hC3C3;
    _XDTACK = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (ACK !== 1'b1 && n < 20);
    if (ACK !== 1'b1) bound_fail("drop_ack");
    host_release();
    wait_idle("drop_idle");

    // Reset pulsed during WAIT: outputs return to idle levels immediately.
    issue(1'b0, 1'b1, 1'b1, 23'h006000, 16'h7777);
    wait_as_low("rst_as");
    tick();
    #2;
    _RST = 1'b0;
    #1;
    check("rst_async", {25'd0, _XAS, _XUDS, _XLDS, XA_OE, XD_OE, BUSY, ACK}, 32'b1110000);
    check("rst_rdata", {16'd0, RDATA}, 32'h0000);
    REQ = 1'b0;
    tick();
    _RST = 1'b1;
    repeat (2) tick();
    check("rst_idle", {31'd0, BUSY}, 32'd0);

    repeat (3) tick();
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
